// File: rtl/blob_bbox_tracker_pkg.sv
// Shared camera definitions: RGB565 marker colour, tracker FSM encoding and default frame geometry.
package blob_bbox_tracker_pkg;

    localparam logic [15:0] RGB565_GREEN = 16'h07E0;

    localparam int unsigned DEFAULT_WIDTH      = 640;
    localparam int unsigned DEFAULT_HEIGHT     = 480;
    localparam int unsigned DEFAULT_COORD_BITS = 10;
    localparam int unsigned DEFAULT_COUNT_BITS = 19;
    localparam int unsigned DEFAULT_MIN_PIXELS = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

endpackage

// File: rtl/blob_bbox_tracker_minmax.sv
// One axis of the bounding box: widens [cur_min, cur_max] to include coord when hit is set.
module bbox_minmax_update #(
    parameter int unsigned BITS = 10
) (
    input  logic [BITS-1:0] cur_min,
    input  logic [BITS-1:0] cur_max,
    input  logic [BITS-1:0] coord,
    input  logic            hit,
    output logic [BITS-1:0] next_min,
    output logic [BITS-1:0] next_max
);

    always_comb begin
        next_min = cur_min;
        next_max = cur_max;
        if (hit) begin
            if (coord < cur_min) next_min = coord;
            if (coord > cur_max) next_max = coord;
        end
    end

endmodule

// File: rtl/blob_bbox_tracker.sv
// Counts MATCH_COLOR pixels in a thresholded camera frame, tracks their bounding box,
// and publishes the per-frame result through a valid/ack register handshake.
module blob_bbox_tracker
    import blob_bbox_tracker_pkg::*;
#(
    parameter int unsigned WIDTH       = DEFAULT_WIDTH,
    parameter int unsigned HEIGHT      = DEFAULT_HEIGHT,
    parameter int unsigned COORD_BITS  = DEFAULT_COORD_BITS,
    parameter int unsigned COUNT_BITS  = DEFAULT_COUNT_BITS,
    parameter logic [15:0] MATCH_COLOR = RGB565_GREEN,
    parameter int unsigned MIN_PIXELS  = DEFAULT_MIN_PIXELS
) (
    input  logic                  clock,
    input  logic                  nReset,
    input  logic                  frameStart,
    input  logic                  lineEnd,
    input  logic                  frameEnd,
    input  logic                  pixelValid,
    input  logic [15:0]           pixelData,
    input  logic                  resultAck,
    output logic                  resultValid,
    output logic                  blobFound,
    output logic [COORD_BITS-1:0] minX,
    output logic [COORD_BITS-1:0] maxX,
    output logic [COORD_BITS-1:0] minY,
    output logic [COORD_BITS-1:0] maxY,
    output logic [COUNT_BITS-1:0] pixelCount,
    output logic                  overrun,
    output logic                  busy
);

    localparam logic [COORD_BITS-1:0] X_LIM = COORD_BITS'(WIDTH);
    localparam logic [COORD_BITS-1:0] Y_LIM = COORD_BITS'(HEIGHT);
    localparam logic [COUNT_BITS-1:0] MIN_LIM = COUNT_BITS'(MIN_PIXELS);

    state_t                state;
    logic [COORD_BITS-1:0] x, y;
    logic [COORD_BITS-1:0] min_x_acc, max_x_acc, min_y_acc, max_y_acc;
    logic [COORD_BITS-1:0] min_x_nxt, max_x_nxt, min_y_nxt, max_y_nxt;
    logic [COUNT_BITS-1:0] count, count_nxt;
    logic                  pix_ok, hit, latch;

    always_comb begin
        pix_ok    = pixelValid && (x < X_LIM) && (y < Y_LIM);
        hit       = (state == ACCUM) && pix_ok && (pixelData == MATCH_COLOR);
        count_nxt = (hit && (count != '1)) ? count + COUNT_BITS'(1) : count;
        latch     = (state == ACCUM) && frameEnd && !frameStart;
    end

    bbox_minmax_update #(.BITS(COORD_BITS)) u_x_axis (
        .cur_min (min_x_acc),
        .cur_max (max_x_acc),
        .coord   (x),
        .hit     (hit),
        .next_min(min_x_nxt),
        .next_max(max_x_nxt)
    );

    bbox_minmax_update #(.BITS(COORD_BITS)) u_y_axis (
        .cur_min (min_y_acc),
        .cur_max (max_y_acc),
        .coord   (y),
        .hit     (hit),
        .next_min(min_y_nxt),
        .next_max(max_y_nxt)
    );

    assign busy = (state == ACCUM);

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state       <= IDLE;
            x           <= '0;
            y           <= '0;
            count       <= '0;
            min_x_acc   <= '0;
            max_x_acc   <= '0;
            min_y_acc   <= '0;
            max_y_acc   <= '0;
            resultValid <= 1'b0;
            blobFound   <= 1'b0;
            minX        <= '0;
            maxX        <= '0;
            minY        <= '0;
            maxY        <= '0;
            pixelCount  <= '0;
            overrun     <= 1'b0;
        end else begin
            // frameStart wins in both states: it opens a frame or aborts the current one.
            if (frameStart) begin
                state     <= ACCUM;
                x         <= '0;
                y         <= '0;
                count     <= '0;
                min_x_acc <= '1;
                min_y_acc <= '1;
                max_x_acc <= '0;
                max_y_acc <= '0;
            end else if (state == ACCUM) begin
                count     <= count_nxt;
                min_x_acc <= min_x_nxt;
                max_x_acc <= max_x_nxt;
                min_y_acc <= min_y_nxt;
                max_y_acc <= max_y_nxt;
                if (lineEnd) begin
                    x <= '0;
                    if (y < Y_LIM) y <= y + COORD_BITS'(1);
                end else if (pix_ok) begin
                    x <= x + COORD_BITS'(1);
                end
                if (frameEnd) state <= IDLE;
            end

            // Result latch uses the next-state accumulators so a pixel on the frameEnd cycle counts.
            if (latch) begin
                resultValid <= 1'b1;
                pixelCount  <= count_nxt;
                blobFound   <= (count_nxt >= MIN_LIM);
                if (count_nxt == '0) begin
                    minX <= '0;
                    maxX <= '0;
                    minY <= '0;
                    maxY <= '0;
                end else begin
                    minX <= min_x_nxt;
                    maxX <= max_x_nxt;
                    minY <= min_y_nxt;
                    maxY <= max_y_nxt;
                end
                if (resultValid && !resultAck) overrun <= 1'b1;
            end else if (resultValid && resultAck) begin
                resultValid <= 1'b0;
                overrun     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_blob_bbox_tracker.sv
// Directed bench for blob_bbox_tracker: table of block-shaped frames plus hand sequences
// for idle behaviour, sparse hits, overrun/ack interplay, abort, async reset and clamping.
module tb_blob_bbox_tracker;

    logic        clock = 1'b0;
    logic        nReset;
    logic        frameStart, lineEnd, frameEnd, pixelValid, resultAck;
    logic [15:0] pixelData;
    logic        resultValid, blobFound, overrun, busy;
    logic [9:0]  minX, maxX, minY, maxY;
    logic [18:0] pixelCount;

    int n_checks = 0;
    int n_fail   = 0;
    logic pre_fe_valid;
    logic ack_on_fe = 1'b0;

    typedef struct {
        int   x0, y0, w, h;
        int   cnt, mnx, mxx, mny, mxy;
        logic found;
    } vec_t;
    vec_t vecs[5];

    blob_bbox_tracker #(
        .WIDTH(640), .HEIGHT(480), .COORD_BITS(10), .COUNT_BITS(19),
        .MATCH_COLOR(16'h07E0), .MIN_PIXELS(16)
    ) dut (
        .clock(clock), .nReset(nReset), .frameStart(frameStart), .lineEnd(lineEnd),
        .frameEnd(frameEnd), .pixelValid(pixelValid), .pixelData(pixelData),
        .resultAck(resultAck), .resultValid(resultValid), .blobFound(blobFound),
        .minX(minX), .maxX(maxX), .minY(minY), .maxY(maxY), .pixelCount(pixelCount),
        .overrun(overrun), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_res(input string tag, input logic v, input logic f, input int mnx,
                             input int mxx, input int mny, input int mxy, input int cnt,
                             input logic ov);
        check({tag, " resultValid"}, 32'(resultValid), 32'(v));
        check({tag, " blobFound"},   32'(blobFound), 32'(f));
        check({tag, " minX"},        32'(minX), mnx);
        check({tag, " maxX"},        32'(maxX), mxx);
        check({tag, " minY"},        32'(minY), mny);
        check({tag, " maxY"},        32'(maxY), mxy);
        check({tag, " pixelCount"},  32'(pixelCount), cnt);
        check({tag, " overrun"},     32'(overrun), 32'(ov));
    endtask

    task automatic frame_begin();
        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
    endtask

    task automatic ack();
        resultAck = 1'b1;
        tick();
        resultAck = 1'b0;
    endtask

    // n pixels, matching where lo<=x<=hi; lineEnd/frameEnd ride on the last pixel (or alone if n==0).
    task automatic send_line(input int n, input int lo, input int hi, input logic le, input logic fe);
        if (n == 0) begin
            lineEnd  = le;
            frameEnd = fe;
            if (fe) begin
                resultAck    = ack_on_fe;
                pre_fe_valid = resultValid;
            end
            tick();
        end else begin
            for (int i = 0; i < n; i++) begin
                pixelValid = 1'b1;
                pixelData  = (i >= lo && i <= hi) ? 16'h07E0 : ((i % 2 == 0) ? 16'h07E1 : 16'hFFFF);
                if (i == n - 1) begin
                    lineEnd  = le;
                    frameEnd = fe;
                    if (fe) begin
                        resultAck    = ack_on_fe;
                        pre_fe_valid = resultValid;
                    end
                end
                tick();
            end
        end
        pixelValid = 1'b0;
        pixelData  = 16'h0000;
        lineEnd    = 1'b0;
        frameEnd   = 1'b0;
        resultAck  = 1'b0;
    endtask

    task automatic run_block(input int x0, input int y0, input int w, input int h);
        frame_begin();
        if (h == 0) begin
            for (int yy = 0; yy < y0; yy++) send_line(0, 0, -1, 1'b1, 1'b0);
            send_line(0, 0, -1, 1'b0, 1'b1);
        end else begin
            for (int yy = 0; yy < y0 + h; yy++) begin
                if (yy < y0) send_line(0, 0, -1, 1'b1, 1'b0);
                else send_line(x0 + w, x0, x0 + w - 1, yy != y0 + h - 1, yy == y0 + h - 1);
            end
        end
    endtask

    initial begin
        vecs[0] = '{x0:300, y0:50,  w:8,  h:4, cnt:32, mnx:300, mxx:307, mny:50,  mxy:53,  found:1'b1};
        vecs[1] = '{x0:0,   y0:3,   w:0,  h:0, cnt:0,  mnx:0,   mxx:0,   mny:0,   mxy:0,   found:1'b0};
        vecs[2] = '{x0:0,   y0:0,   w:1,  h:1, cnt:1,  mnx:0,   mxx:0,   mny:0,   mxy:0,   found:1'b0};
        vecs[3] = '{x0:636, y0:476, w:4,  h:4, cnt:16, mnx:636, mxx:639, mny:476, mxy:479, found:1'b1};
        vecs[4] = '{x0:0,   y0:0,   w:15, h:1, cnt:15, mnx:0,   mxx:14,  mny:0,   mxy:0,   found:1'b0};

        nReset = 1'b0;
        frameStart = 1'b0; lineEnd = 1'b0; frameEnd = 1'b0;
        pixelValid = 1'b0; pixelData = 16'h0000; resultAck = 1'b0;
        repeat (3) tick();
        check_res("reset", 1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b0);
        check("reset busy", 32'(busy), 0);
        nReset = 1'b1;
        tick();

        // Idle: pixels, lineEnd and frameEnd without frameStart are ignored
        for (int i = 0; i < 100; i++) begin
            pixelValid = 1'b1;
            pixelData  = 16'h07E0;
            lineEnd    = (i == 50);
            frameEnd   = (i == 60);
            tick();
        end
        pixelValid = 1'b0; lineEnd = 1'b0; frameEnd = 1'b0;
        tick();
        check_res("idle", 1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b0);
        check("idle busy", 32'(busy), 0);

        // Sparse hits at (10,20), (100,200), (639,479); last one shares its cycle with frameEnd
        frame_begin();
        check("sparse busy", 32'(busy), 1);
        for (int yy = 0; yy < 480; yy++) begin
            if (yy == 20)       send_line(11, 10, 10, 1'b1, 1'b0);
            else if (yy == 200) send_line(101, 100, 100, 1'b1, 1'b0);
            else if (yy == 479) send_line(640, 639, 639, 1'b0, 1'b1);
            else                send_line(0, 0, -1, 1'b1, 1'b0);
        end
        check_res("sparse", 1'b1, 1'b0, 10, 639, 20, 479, 3, 1'b0);
        check("sparse busy after", 32'(busy), 0);
        ack();
        check("sparse ack", 32'(resultValid), 0);

        for (int i = 0; i < 5; i++) begin
            run_block(vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h);
            check($sformatf("vec%0d valid before edge", i), 32'(pre_fe_valid), 0);
            check_res($sformatf("vec%0d", i), 1'b1, vecs[i].found, vecs[i].mnx, vecs[i].mxx,
                      vecs[i].mny, vecs[i].mxy, vecs[i].cnt, 1'b0);
            repeat (3) tick();
            check($sformatf("vec%0d held valid", i), 32'(resultValid), 1);
            check($sformatf("vec%0d held count", i), 32'(pixelCount), vecs[i].cnt);
            ack();
            check($sformatf("vec%0d acked", i), 32'(resultValid), 0);
        end

        // Overrun: two frames without ack
        run_block(5, 5, 1, 1);
        check_res("ovr first", 1'b1, 1'b0, 5, 5, 5, 5, 1, 1'b0);
        run_block(7, 8, 2, 1);
        check_res("ovr second", 1'b1, 1'b0, 7, 8, 8, 8, 2, 1'b1);
        ack_on_fe = 1'b1;
        run_block(1, 1, 1, 1);
        ack_on_fe = 1'b0;
        check_res("ovr latch+ack", 1'b1, 1'b0, 1, 1, 1, 1, 1, 1'b1);
        ack();
        check("ovr ack valid", 32'(resultValid), 0);
        check("ovr ack overrun", 32'(overrun), 0);
        ack();
        check("stray ack valid", 32'(resultValid), 0);
        check("stray ack overrun", 32'(overrun), 0);
        run_block(2, 2, 1, 1);
        check_res("pend", 1'b1, 1'b0, 2, 2, 2, 2, 1, 1'b0);
        ack_on_fe = 1'b1;
        run_block(3, 3, 1, 1);
        ack_on_fe = 1'b0;
        check_res("same-cycle ack", 1'b1, 1'b0, 3, 3, 3, 3, 1, 1'b0);
        ack();
        check("same-cycle ack cleared", 32'(resultValid), 0);

        // Abort after 100 hits, then a clean 20-hit frame
        frame_begin();
        send_line(100, 0, 99, 1'b1, 1'b0);
        frame_begin();
        check("abort no result", 32'(resultValid), 0);
        check("abort busy", 32'(busy), 1);
        send_line(0, 0, -1, 1'b1, 1'b0);
        send_line(0, 0, -1, 1'b1, 1'b0);
        send_line(20, 0, 19, 1'b0, 1'b1);
        check_res("after abort", 1'b1, 1'b1, 0, 19, 2, 2, 20, 1'b0);

        // Async reset mid-frame with an unacknowledged result pending
        frame_begin();
        send_line(5, 0, 4, 1'b1, 1'b0);
        nReset = 1'b0;
        #1;
        check_res("async reset", 1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b0);
        check("async reset busy", 32'(busy), 0);
        tick();
        nReset = 1'b1;
        tick();
        check("post reset busy", 32'(busy), 0);

        // Clamping: 645 hits on a line (x stops at WIDTH), then pixels below the last line
        frame_begin();
        send_line(645, 0, 644, 1'b1, 1'b0);
        for (int yy = 0; yy < 481; yy++) send_line(0, 0, -1, 1'b1, 1'b0);
        send_line(3, 0, 2, 1'b0, 1'b1);
        check("clamp valid before edge", 32'(pre_fe_valid), 0);
        check_res("clamp", 1'b1, 1'b1, 0, 639, 0, 0, 640, 1'b0);
        ack();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
